// File: rtl/reg_file_sb_if.sv
// Decode / write-back side bundle of the RV32I integer register file.
// master = pipeline stages driving the file, slave = the register file itself.
interface reg_file_sb_if #(
    parameter int XLEN = 32
);
    logic            REG_write_i;
    logic [XLEN-1:0] REG_data_i;
    logic [4:0]      REG_addr_i;
    logic [4:0]      rs1_addr_i;
    logic [4:0]      rs2_addr_i;
    logic            rs1_used_i;
    logic            rs2_used_i;
    logic [XLEN-1:0] rs1_data_o;
    logic [XLEN-1:0] rs2_data_o;
    logic            mark_busy_i;
    logic [4:0]      mark_addr_i;
    logic            flush_i;
    logic            stall_o;
    logic [5:0]      pending_cnt_o;

    modport master (
        output REG_write_i, REG_data_i, REG_addr_i,
        output rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        output mark_busy_i, mark_addr_i, flush_i,
        input  rs1_data_o, rs2_data_o, stall_o, pending_cnt_o
    );

    modport slave (
        input  REG_write_i, REG_data_i, REG_addr_i,
        input  rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        input  mark_busy_i, mark_addr_i, flush_i,
        output rs1_data_o, rs2_data_o, stall_o, pending_cnt_o
    );
endinterface

// File: rtl/reg_file_sb.sv
// RV32I integer register file with write-back bypass and a per-register
// pending-load scoreboard that stalls decode on unresolved load destinations.
module reg_file_sb #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_sb_if.slave bus
);

    logic [XLEN-1:0]  r_regs [0:NREGS-1];
    logic [NREGS-1:0] r_busy;
    logic [5:0]       r_pending_cnt;
    logic [NREGS-1:0] w_busy_next;
    logic [XLEN-1:0]  w_rs1_data;
    logic [XLEN-1:0]  w_rs2_data;
    logic             w_stall;

    function automatic logic [5:0] popcount(input logic [NREGS-1:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

    function automatic logic [XLEN-1:0] read_port(
        input logic [4:0]      a,
        input logic            wr,
        input logic [4:0]      waddr,
        input logic [XLEN-1:0] wdata,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] d;
        if (a == 5'd0) begin
            d = '0;
        end else if (wr && (waddr == a)) begin
            d = wdata;
        end else begin
            d = stored;
        end
        return d;
    endfunction

    // A committing write to the same register resolves the hazard via bypass.
    function automatic logic hazard(
        input logic [4:0] a,
        input logic       busy_bit,
        input logic       wr,
        input logic [4:0] waddr
    );
        return (a != 5'd0) && busy_bit && !(wr && (waddr == a));
    endfunction

    // Scoreboard next state: flush beats mark, mark beats the commit clear.
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            if (bus.flush_i) begin
                w_busy_next[i] = 1'b0;
            end else if (bus.mark_busy_i && (bus.mark_addr_i == 5'(i))) begin
                w_busy_next[i] = 1'b1;
            end else if (bus.REG_write_i && (bus.REG_addr_i == 5'(i))) begin
                w_busy_next[i] = 1'b0;
            end else begin
                w_busy_next[i] = r_busy[i];
            end
        end
        w_busy_next[0] = 1'b0;
    end

    // Read ports and decode stall.
    always_comb begin
        w_rs1_data = read_port(bus.rs1_addr_i, bus.REG_write_i, bus.REG_addr_i,
                               bus.REG_data_i, r_regs[bus.rs1_addr_i]);
        w_rs2_data = read_port(bus.rs2_addr_i, bus.REG_write_i, bus.REG_addr_i,
                               bus.REG_data_i, r_regs[bus.rs2_addr_i]);
        w_stall    = (bus.rs1_used_i && hazard(bus.rs1_addr_i, r_busy[bus.rs1_addr_i],
                                               bus.REG_write_i, bus.REG_addr_i))
                  || (bus.rs2_used_i && hazard(bus.rs2_addr_i, r_busy[bus.rs2_addr_i],
                                               bus.REG_write_i, bus.REG_addr_i));
    end

    // Register array, busy vector and pending count; x0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy        <= '0;
            r_pending_cnt <= 6'd0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (bus.REG_write_i && (bus.REG_addr_i == 5'(i))) begin
                    r_regs[i] <= bus.REG_data_i;
                end
            end
            r_busy        <= w_busy_next;
            r_pending_cnt <= popcount(w_busy_next);
        end
    end

    assign bus.rs1_data_o    = w_rs1_data;
    assign bus.rs2_data_o    = w_rs2_data;
    assign bus.stall_o       = w_stall;
    assign bus.pending_cnt_o = r_pending_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb: reads, bypass, scoreboard,
// flush priority and asynchronous reset.
module tb_reg_file_sb;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    reg_file_sb_if #(.XLEN(32)) bus ();

    reg_file_sb #(.NREGS(32), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        mk;
        logic [4:0]  maddr;
        logic        fl;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic        e_stall;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.REG_write_i = v.wr;
        bus.REG_data_i  = v.wdata;
        bus.REG_addr_i  = v.waddr;
        bus.rs1_addr_i  = v.rs1;
        bus.rs2_addr_i  = v.rs2;
        bus.rs1_used_i  = v.u1;
        bus.rs2_used_i  = v.u2;
        bus.mark_busy_i = v.mk;
        bus.mark_addr_i = v.maddr;
        bus.flush_i     = v.fl;
    endtask

    task automatic idle();
        vec_t v;
        v = '{1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0,
              32'h0, 32'h0, 1'b0, 6'd0};
        drive(v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();

        //          wr    wdata         wa    rs1   rs2   u1    u2    mk    ma    fl    e_rs1         e_rs2         stall cnt
        vecs.push_back('{1'b1, 32'hDEADBEEF, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 6'd0});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd5,  5'd5,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 6'd0});
        vecs.push_back('{1'b1, 32'h00001234, 5'd0,  5'd0,  5'd5,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 6'd0});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        1'b0, 6'd0});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd0,  5'd7,  1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 32'h0,        32'h0,        1'b0, 6'd1});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        1'b1, 6'd1});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd0,  5'd7,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        1'b0, 6'd1});
        vecs.push_back('{1'b1, 32'h00000055, 5'd7,  5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0,        32'h00000055, 1'b0, 6'd0});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0,        32'h00000055, 1'b0, 6'd0});
        vecs.push_back('{1'b1, 32'h000000AA, 5'd9,  5'd9,  5'd0,  1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 32'h000000AA, 32'h0,        1'b0, 6'd1});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 32'h000000AA, 32'h0,        1'b1, 6'd1});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 32'h0,        32'h0,        1'b0, 6'd0});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 32'h0,        32'h0,        1'b0, 6'd1});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 32'h0,        32'h0,        1'b0, 6'd2});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 32'h0,        32'h0,        1'b0, 6'd3});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd3,  5'd4,  1'b1, 1'b1, 1'b1, 5'd6,  1'b1, 32'h0,        32'h0,        1'b1, 6'd0});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd5,  5'd6,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 6'd0});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd3,  5'd4,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        1'b0, 6'd0});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 32'h0,        32'h0,        1'b0, 6'd0});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 32'h0,        32'h0,        1'b0, 6'd1});
        vecs.push_back('{1'b1, 32'h00000013, 5'd13, 5'd12, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        1'b1, 6'd1});
        vecs.push_back('{1'b0, 32'h0,        5'd0,  5'd13, 5'd12, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 32'h00000013, 32'h0,        1'b1, 6'd1});

        // Reset state: every register reads zero on both ports.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        chk("reset_stall", {31'd0, bus.stall_o}, 32'h0);
        chk("reset_cnt", {26'd0, bus.pending_cnt_o}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            bus.rs1_addr_i = 5'(i);
            bus.rs2_addr_i = 5'(31 - i);
            bus.rs1_used_i = 1'b1;
            bus.rs2_used_i = 1'b1;
            #1;
            chk($sformatf("reset_rs1_x%0d", i), bus.rs1_data_o, 32'h0);
            chk($sformatf("reset_rs2_x%0d", 31 - i), bus.rs2_data_o, 32'h0);
            chk($sformatf("reset_stall_x%0d", i), {31'd0, bus.stall_o}, 32'h0);
        end
        idle();

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            drive(vecs[k]);
            #2;
            chk($sformatf("v%0d_rs1", k), bus.rs1_data_o, vecs[k].e_rs1);
            chk($sformatf("v%0d_rs2", k), bus.rs2_data_o, vecs[k].e_rs2);
            chk($sformatf("v%0d_stall", k), {31'd0, bus.stall_o}, {31'd0, vecs[k].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cnt", k), {26'd0, bus.pending_cnt_o}, {26'd0, vecs[k].e_cnt});
            idle();
        end

        // Asynchronous reset between edges while x10 is busy holding 0x77.
        @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        idle();
        bus.REG_write_i = 1'b1;
        bus.REG_addr_i  = 5'd10;
        bus.REG_data_i  = 32'h00000077;
        bus.mark_busy_i = 1'b1;
        bus.mark_addr_i = 5'd10;
        @(posedge clk);
        #1;
        idle();
        bus.rs1_addr_i = 5'd10;
        bus.rs1_used_i = 1'b1;
        #2;
        chk("pre_rst_rs1", bus.rs1_data_o, 32'h00000077);
        chk("pre_rst_stall", {31'd0, bus.stall_o}, 32'h1);
        chk("pre_rst_cnt", {26'd0, bus.pending_cnt_o}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_rs1", bus.rs1_data_o, 32'h0);
        chk("async_rst_stall", {31'd0, bus.stall_o}, 32'h0);
        chk("async_rst_cnt", {26'd0, bus.pending_cnt_o}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
